// File: rtl/bcd_chain_seq.sv
// -----------------------------------------------------------------------------
// bcd_chain_seq
//
// Multi-byte packed-BCD adder/subtractor. Each operation runs one 8-bit binary
// add or subtract per byte, followed by a decimal-adjust pass that follows the
// Z80 DAA rules. Bytes are processed least-significant first, and the decimal
// carry/borrow is chained from one byte into the next. The block sits beside
// the CPU ALU, handles score/timer arithmetic, and is the multi-cycle user of
// the DAA correction datapath.
//
// Parameters
//   NBYTES     number of packed-BCD bytes per operand (1..8)
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   start      request pulse; sampled only in IDLE
//   sub        0 = add, 1 = subtract (a - b)
//   carry_in   initial carry/borrow into byte 0
//   a_in       operand A, packed BCD, byte 0 = bits 7:0
//   b_in       operand B, packed BCD
//   busy       high from the first ADD cycle through DONE
//   done       one-cycle pulse; result, carry_out and zero_out are valid
//   result     BCD result; bytes update progressively during the operation
//   carry_out  final decimal carry (add) or borrow (sub)
//   zero_out   result == 0
//   invalid    some nibble of the latched A or B was greater than 9
// -----------------------------------------------------------------------------
module bcd_chain_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                sub,
    input  logic                carry_in,
    input  logic [8*NBYTES-1:0] a_in,
    input  logic [8*NBYTES-1:0] b_in,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                zero_out,
    output logic                invalid
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_ADJ,
        S_DONE
    } state_t;

    state_t        state;

    // Operands latched at the accepting edge; later input changes are ignored.
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;
    logic          c_q;       // running decimal carry/borrow between bytes
    logic [IW-1:0] idx;       // byte currently being processed

    // Binary stage results, handed from ADD to ADJ.
    logic [7:0]    s_q;
    logic          h_q;
    logic          cb_q;

    // Returns 1 if any nibble of the operand is not a decimal digit.
    function automatic logic has_bad_nibble(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int n = 0; n < 2 * NBYTES; n++) begin
            if (v[4*n +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // -------------------------------------------------------------------------
    // Byte selection
    // -------------------------------------------------------------------------
    logic [7:0] x;
    logic [7:0] y;

    // NOTE: every variable assigned in an always_comb block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        x = 8'h00;
        y = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                x = a_q[8*i +: 8];
                y = b_q[8*i +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Binary add/sub stage
    // -------------------------------------------------------------------------
    // The adder is widened by one bit. For an add, the extra bit is the carry
    // out. For a subtract, the extra bit is the sign of the true difference,
    // which is the borrow. The same reasoning applies to the low nibble for H.
    logic [8:0] bin_full;
    logic [4:0] bin_low;
    logic [7:0] s_next;
    logic       h_next;
    logic       cb_next;

    always_comb begin
        if (sub_q) begin
            bin_full = {1'b0, x} - {1'b0, y} - 9'(c_q);
            bin_low  = {1'b0, x[3:0]} - {1'b0, y[3:0]} - 5'(c_q);
        end else begin
            bin_full = {1'b0, x} + {1'b0, y} + 9'(c_q);
            bin_low  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + 5'(c_q);
        end
        s_next  = bin_full[7:0];
        h_next  = bin_low[4];
        cb_next = bin_full[8];
    end

    // -------------------------------------------------------------------------
    // Decimal adjust stage
    // -------------------------------------------------------------------------
    logic [7:0]   corr;
    logic         cn;
    logic [7:0]   adj_byte;
    logic [W-1:0] result_next;

    always_comb begin
        corr = 8'h00;
        cn   = 1'b0;
        if (h_q || (s_q[3:0] > 4'd9)) begin
            corr = corr | 8'h06;
        end
        if (cb_q || (s_q > 8'h99)) begin
            corr = corr | 8'h60;
            cn   = 1'b1;
        end
        adj_byte = sub_q ? (s_q - corr) : (s_q + corr);

        // Result vector with the adjusted byte written into slot idx.
        result_next = result;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                result_next[8*i +: 8] = adj_byte;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge, whatever the order of
    // the statements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the datapath registers are reset along with the control
            // state, so a reset in the middle of an operation leaves nothing
            // half-updated and all outputs read zero right away.
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            c_q       <= 1'b0;
            idx       <= '0;
            s_q       <= 8'h00;
            h_q       <= 1'b0;
            cb_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        sub_q   <= sub;
                        c_q     <= carry_in;
                        idx     <= '0;
                        invalid <= has_bad_nibble(a_in) | has_bad_nibble(b_in);
                        busy    <= 1'b1;
                        state   <= S_ADD;
                    end
                end

                S_ADD: begin
                    s_q   <= s_next;
                    h_q   <= h_next;
                    cb_q  <= cb_next;
                    state <= S_ADJ;
                end

                S_ADJ: begin
                    result <= result_next;
                    c_q    <= cn;
                    if (idx == IW'(NBYTES - 1)) begin
                        // Flags are taken from the final byte's values, so
                        // they are stable during the single done cycle.
                        carry_out <= cn;
                        zero_out  <= (result_next == '0);
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= S_ADD;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_chain_seq.md
Name: bcd_chain_seq

Overview:
- Sequencer that performs multi-byte packed-BCD add/subtract by running one 8-bit binary add/sub per byte, then the decimal-adjust correction pass (Z80 DAA rules), least-significant byte first, with the carry chained between bytes.
- Sits beside the CPU ALU. It serves score/timer arithmetic and acts as the multi-cycle user of the DAA correction datapath.

Parameters:
- NBYTES, 4, number of packed-BCD bytes per operand (1..8).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a - b).
- carry_in  input  1  initial carry/borrow into byte 0.
- a_in  input  8*NBYTES  operand A, packed BCD, byte 0 = bits 7:0.
- b_in  input  8*NBYTES  operand B.
- busy  output  1  high from the first ADD cycle through DONE.
- done  output  1  one-cycle pulse; result valid.
- result  output  8*NBYTES  BCD result.
- carry_out  output  1  final decimal carry/borrow.
- zero_out  output  1  result == 0.
- invalid  output  1  any input nibble of A or B > 9.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, carry_out=0, zero_out=0, invalid=0, all internal registers 0. Reset mid-operation aborts immediately with no partial update.
- States: IDLE, ADD, ADJ, DONE.
- IDLE:
  - On start=1, latch a_in, b_in, sub and carry_in; set idx=0 and c=carry_in.
  - Compute invalid from the latched operands (registered at the same edge).
  - Next state ADD.
  - start=0 stays in IDLE with outputs held.
- ADD (byte idx), with x=A[idx], y=B[idx]:
  - Add: s=(x+y+c)[7:0]; H=carry out of bit 3; Cb=carry out of bit 7.
  - Sub: s=(x-y-c)[7:0]; H=borrow from bit 4; Cb=borrow out of bit 7.
  - Register s, H, Cb. Next state ADJ.
- ADJ:
  - corr=0.
  - If H=1 or s[3:0]>9: corr|=0x06.
  - If Cb=1 or s>0x99: corr|=0x60 and Cn=1; otherwise Cn=0.
  - byte = sub ? s-corr : s+corr, mod 256.
  - Write result[idx]=byte and set c=Cn.
  - If idx==NBYTES-1, go to DONE; else idx+=1 and go to ADD.
- DONE:
  - done=1 for exactly this cycle.
  - carry_out=c; zero_out=(result==0), registered on entry.
  - Next state IDLE.
- Latency: done is high in the cycle following the 2*NBYTES-th clock edge after the edge that sampled start. The next start is accepted the cycle after done.
- start while busy (ADD/ADJ/DONE) is ignored with no queuing. Input changes after the latch edge have no effect.
- result, carry_out, zero_out and invalid hold their values until the next accepted start. result bytes update progressively during the operation and are valid only when done=1.
- Invalid BCD input: computation still follows the rules above exactly; invalid=1 only flags it, no error state.
- All arithmetic wraps mod 256 per byte; no overflow beyond carry_out.

Test Plan:
- NBYTES=2, add 0x0199+0x0001, carry_in=0 -> result 0x0200, carry_out=0, zero_out=0, invalid=0; done exactly 4 edges after start.
- Add 0x9999+0x0001 -> result 0x0000, carry_out=1, zero_out=1.
- Sub 0x0100-0x0001 -> result 0x0099, carry_out=0. Sub 0x0000-0x0001 -> 0x9999, carry_out=1.
- Add 0x00A0+0x0000 -> invalid=1, result matches the rule model (0x0100, carry 0). Also run a randomized valid-BCD sweep against a decimal reference model for add and sub.
- Assert start again during ADJ of byte 0 -> ignored; the single done shows the first operation's result. start in the DONE cycle is also ignored.
- Assert reset in the second ADD cycle -> all outputs 0 immediately, state IDLE; a following start completes normally.
